// File: rtl/i2c_req_arbiter_pkg.sv
// Shared definitions for the I2C request arbiter: FSM encoding, descriptor
// field widths and the default watchdog limit.
package i2c_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } arbState_t;

    localparam int DEV_W  = 7;
    localparam int RW_W   = 1;
    localparam int REG_W  = 8;
    localparam int DATA_W = 8;

    localparam int DEF_TIMEOUT_W   = 20;
    localparam int DEF_TIMEOUT_CYC = 1000000;

endpackage

// File: rtl/i2c_req_arbiter_rr_pick.sv
// Combinational round-robin first-one finder: searches upward from 'start',
// wrapping at pNum, and reports the first set request bit.
module rr_pick #(
    parameter int pNum  = 2,
    parameter int pIdxW = 1
) (
    input  logic [pNum-1:0]  req,
    input  logic [pIdxW-1:0] start,
    output logic [pIdxW-1:0] idx,
    output logic             found
);

    logic [pIdxW:0] cand;

    // Walk offsets from far to near so the nearest hit is the last one written.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = pNum - 1; k >= 0; k--) begin
            cand = {1'b0, start} + (pIdxW + 1)'(k);
            if (cand >= (pIdxW + 1)'(pNum)) begin
                cand = cand - (pIdxW + 1)'(pNum);
            end
            if (req[cand[pIdxW-1:0]]) begin
                idx   = cand[pIdxW-1:0];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Round-robin scheduler sharing one byte-level I2C master among pReqNum
// requesters, with a watchdog supervising each access.
module i2c_req_arbiter
    import i2c_pkg::*;
#(
    parameter int pReqNum     = 2,
    parameter int pTimeoutW   = DEF_TIMEOUT_W,
    parameter int pTimeoutCyc = DEF_TIMEOUT_CYC
) (
    input  logic                       iSCLK,
    input  logic                       iSRST,
    input  logic                       iEn,
    input  logic [pReqNum-1:0]         iReqVd,
    input  logic [pReqNum*DEV_W-1:0]   iReqDev,
    input  logic [pReqNum*RW_W-1:0]    iReqRw,
    input  logic [pReqNum*REG_W-1:0]   iReqReg,
    input  logic [pReqNum*DATA_W-1:0]  iReqWd,
    output logic [pReqNum-1:0]         oReqAck,
    output logic [pReqNum-1:0]         oRspVd,
    output logic [DATA_W-1:0]          oRspRd,
    output logic                       oRspNack,
    output logic                       oRspTo,
    output logic                       oMstStart,
    output logic                       oMstAbort,
    output logic [DEV_W-1:0]           oMstDev,
    output logic [RW_W-1:0]            oMstRw,
    output logic [REG_W-1:0]           oMstReg,
    output logic [DATA_W-1:0]          oMstWd,
    input  logic                       iMstDone,
    input  logic                       iMstNack,
    input  logic [DATA_W-1:0]          iMstRd,
    output logic                       oBusy
);

    localparam int IdxW = $clog2(pReqNum);
    localparam logic [pTimeoutW-1:0] ToLast = pTimeoutW'(pTimeoutCyc - 1);

    arbState_t            state, stateNext;
    logic [IdxW-1:0]      rPtr, rOwn, pickIdx;
    logic                 pickFound;
    logic [pTimeoutW-1:0] wdog;
    logic                 grant, doneHit, expire;

    logic [DEV_W-1:0]  devArr [pReqNum];
    logic [RW_W-1:0]   rwArr  [pReqNum];
    logic [REG_W-1:0]  regArr [pReqNum];
    logic [DATA_W-1:0] wdArr  [pReqNum];

    for (genvar gi = 0; gi < pReqNum; gi++) begin : gUnpack
        assign devArr[gi] = iReqDev[gi*DEV_W +: DEV_W];
        assign rwArr[gi]  = iReqRw[gi*RW_W +: RW_W];
        assign regArr[gi] = iReqReg[gi*REG_W +: REG_W];
        assign wdArr[gi]  = iReqWd[gi*DATA_W +: DATA_W];
    end

    rr_pick #(
        .pNum  (pReqNum),
        .pIdxW (IdxW)
    ) uPick (
        .req   (iReqVd),
        .start (rPtr),
        .idx   (pickIdx),
        .found (pickFound)
    );

    always_comb begin
        stateNext = state;
        grant     = 1'b0;
        doneHit   = 1'b0;
        expire    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (iEn && pickFound) begin
                    grant     = 1'b1;
                    stateNext = ST_ISSUE;
                end
            end
            ST_ISSUE: stateNext = ST_WAIT;
            ST_WAIT: begin
                // A completion in the expiry cycle still counts as a normal finish.
                if (iMstDone) begin
                    doneHit   = 1'b1;
                    stateNext = ST_RESP;
                end else if (wdog == ToLast) begin
                    expire    = 1'b1;
                    stateNext = ST_RESP;
                end
            end
            ST_RESP: stateNext = ST_IDLE;
            default: stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge iSCLK) begin
        if (!iSRST) begin
            state     <= ST_IDLE;
            rPtr      <= '0;
            rOwn      <= '0;
            wdog      <= '0;
            oReqAck   <= '0;
            oRspVd    <= '0;
            oRspRd    <= '0;
            oRspNack  <= 1'b0;
            oRspTo    <= 1'b0;
            oMstStart <= 1'b0;
            oMstAbort <= 1'b0;
            oMstDev   <= '0;
            oMstRw    <= '0;
            oMstReg   <= '0;
            oMstWd    <= '0;
        end else begin
            state     <= stateNext;
            oReqAck   <= '0;
            oRspVd    <= '0;
            oMstStart <= 1'b0;
            oMstAbort <= 1'b0;
            if (grant) begin
                rOwn    <= pickIdx;
                rPtr    <= (pickIdx == IdxW'(pReqNum - 1)) ? '0 : pickIdx + 1'b1;
                oReqAck <= pReqNum'(1) << pickIdx;
                oMstDev <= devArr[pickIdx];
                oMstRw  <= rwArr[pickIdx];
                oMstReg <= regArr[pickIdx];
                oMstWd  <= wdArr[pickIdx];
            end
            if (state == ST_ISSUE) begin
                oMstStart <= 1'b1;
                wdog      <= '0;
            end
            if (state == ST_WAIT) begin
                wdog <= wdog + 1'b1;
            end
            if (doneHit) begin
                oRspVd   <= pReqNum'(1) << rOwn;
                oRspRd   <= iMstRd;
                oRspNack <= iMstNack;
                oRspTo   <= 1'b0;
            end
            if (expire) begin
                oRspVd    <= pReqNum'(1) << rOwn;
                oRspRd    <= '0;
                oRspNack  <= 1'b0;
                oRspTo    <= 1'b1;
                oMstAbort <= 1'b1;
            end
        end
    end

    assign oBusy = (state != ST_IDLE);

endmodule

// File: doc/i2c_req_arbiter.md
# i2c_req_arbiter

Round-robin scheduler that shares the single byte-level I2C master among `pReqNum` on-chip requesters, such as the keypad poller and the MIDI codec configurator. It latches one register-access descriptor at a time and issues it to the master as a start pulse plus a stable command. It then supervises completion with a watchdog and returns read data, NACK and timeout status to the requester that owns the access. It sits between the requesters and the I2C master/mux pair, in the `iSCLK` domain.

## Interface
Parameters:
- `pReqNum`, 2: number of requesters, 2..8.
- `pTimeoutW`, 20: width of the watchdog counter.
- `pTimeoutCyc`, 1000000: watchdog limit in `iSCLK` cycles. Must be `< 2**pTimeoutW`.

Ports:
- `iSCLK` in 1: system clock.
- `iSRST` in 1: reset, synchronous, active-low.
- `iEn` in 1: scheduler enable. When low, no new grants are made.
- `iReqVd` in `pReqNum`: per-requester request, level.
- `iReqDev` in `pReqNum*7`: 7-bit slave address per requester, packed with requester i at bits `[i*7+:7]`.
- `iReqRw` in `pReqNum`: 1 = read, 0 = write.
- `iReqReg` in `pReqNum*8`: register address per requester.
- `iReqWd` in `pReqNum*8`: write data per requester.
- `oReqAck` out `pReqNum`: one-cycle pulse meaning the descriptor was captured.
- `oRspVd` out `pReqNum`: one-cycle pulse meaning the access has finished.
- `oRspRd` out 8: read data. Valid only while `oRspVd` is nonzero.
- `oRspNack` out 1: slave NACK. Valid only while `oRspVd` is nonzero.
- `oRspTo` out 1: watchdog expired. Valid only while `oRspVd` is nonzero.
- `oMstStart` out 1: one-cycle command pulse to the master.
- `oMstAbort` out 1: one-cycle abort pulse to the master.
- `oMstDev` out 7, `oMstRw` out 1, `oMstReg` out 8, `oMstWd` out 8: command fields. Held stable from `oMstStart` until the response is issued.
- `iMstDone` in 1: master completion pulse.
- `iMstNack` in 1: NACK status. Sampled when `iMstDone` is high.
- `iMstRd` in 8: read data. Sampled when `iMstDone` is high.
- `oBusy` out 1: high in every state except IDLE.

## Operation
States: IDLE, ISSUE, WAIT, RESP.

- **IDLE**
  - Enters ISSUE when `iEn` is 1 and `iReqVd` is nonzero.
  - The winner is the first set bit found by searching upward from the priority pointer `rPtr`, wrapping at `pReqNum`.
  - In the same cycle it latches the winner's descriptor into `oMst*` and its index into `rOwn`, pulses `oReqAck[rOwn]`, and sets `rPtr` to `(rOwn+1) mod pReqNum`.
- **ISSUE**
  - Pulses `oMstStart` for one cycle, clears the watchdog, then moves to WAIT.
- **WAIT**
  - The watchdog increments every cycle.
  - If `iMstDone` is 1: latch `iMstRd` and `iMstNack`, clear the timeout flag, go to RESP.
  - Else if the watchdog equals `pTimeoutCyc-1`: pulse `oMstAbort`, set the timeout flag, force read data to 0x00 and NACK to 0, go to RESP.
  - If `iMstDone` and watchdog expiry occur in the same cycle, done wins and `oMstAbort` is not pulsed.
- **RESP**
  - Pulses `oRspVd[rOwn]` with the latched status, then returns to IDLE.
  - A new grant is possible on the cycle after RESP.
- A request is accepted only in the cycle `oReqAck` is high. If a requester keeps `iReqVd` high after its ack, that counts as a new request and is arbitrated fairly with the others.
- `iEn` dropping while an access is in flight has no effect on it; the access completes. Only new grants are blocked.
- Descriptor inputs are ignored outside the grant cycle.
- An `iMstDone` pulse arriving in IDLE, ISSUE or RESP is ignored.

## Timing
- Reset (`iSRST`=0 at a clock edge):
  - State goes to IDLE and `rPtr` to 0.
  - All outputs go to 0, including `oMst*` fields and `oRspRd`.
  - Reset applied mid-access drops that access silently: no `oRspVd`, no `oMstAbort`.
- Minimum latency is 4 cycles:
  - request edge sampled in IDLE → `oReqAck` at cycle 0
  - `oMstStart` at cycle 1
  - earliest `iMstDone` at cycle 2
  - `oRspVd` at cycle 3
- `oReqAck`, `oMstStart`, `oMstAbort` and `oRspVd` are registered outputs, each one cycle wide and one-hot.
- Watchdog: `oMstAbort` fires exactly `pTimeoutCyc` cycles after the first WAIT cycle.
- Throughput is one access per 4 cycles plus the master's time. Back-to-back grants are separated by at least 4 cycles.

## Structure
- Shared package `i2c_pkg` holds the state encoding, the descriptor field widths (7/1/8/8) and the default timeout constant.
- One sub-module, `rr_pick`: a combinational round-robin first-one finder over `pReqNum` bits with a rotating start index. It returns the index and a found flag.
- The watchdog counter, the state register and the descriptor latch live in this module.

## Test plan
- Single write: requester 0 asks for dev 0x20, reg 0x03, wd 0xA5; `iMstDone` arrives 10 cycles after `oMstStart` with NACK 0 → exactly one ack, one start with the fields stable, `oRspVd`=01, nack=0, to=0.
- Contention: both requesters asserted continuously, every access completes OK → grant order 0,1,0,1. Each `oRspVd` goes to the owner, and response read data matches the stubbed `iMstRd` (0x11 for requester 0, 0x22 for requester 1).
- Read with NACK: requester 1 reads reg 0x10; stub returns done with NACK 1 and rd 0x5A → `oRspVd`=10, nack=1, rd=0x5A.
- Timeout: `pTimeoutCyc`=16 and no `iMstDone` → `oMstAbort` 16 cycles into WAIT, then `oRspVd` with to=1 and rd=0x00. Repeat with done and expiry in the same cycle → to=0, no abort.
- `iEn` gating: drop `iEn` during WAIT → the in-flight access completes normally. A pending requester receives no ack until `iEn` returns to 1.
- Reset mid-WAIT: assert `iSRST`=0 → the next cycle shows all outputs 0, no `oRspVd`, and a fresh request is granted to requester 0 first.
